// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : PS/2 scancode history capture, 4-digit 7-seg scan with optional
//            inter-digit blanking (SEG7_BLANK_EN), retriggerable keypress LED.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int SCAN_CYCLES  = 131072,
  parameter int BLANK_CYCLES = 1024,
  parameter int LED_CYCLES   = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic [3:0]  digit_val,
  output logic [3:0]  an,
  output logic        dp,
  output logic        led,
  output logic [15:0] hist
);

  localparam int SLOT_W = $clog2(SCAN_CYCLES);
  localparam int LED_W  = $clog2(LED_CYCLES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);
  localparam logic [LED_W-1:0]  LED_LOAD  = LED_W'(LED_CYCLES);

  logic [15:0]       hist_q, hist_d;
  logic              brk_q, brk_d;
  logic [LED_W-1:0]  led_cnt_q, led_cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        digit_val_q, digit_val_d;
  logic [3:0]        an_q, an_d;
  logic              dp_q, dp_d;
  logic              led_q, led_d;
  logic              is_make;
  logic              active;

`ifdef SEG7_BLANK_EN
  typedef enum logic [0:0] {ST_ACTIVE = 1'b0, ST_BLANK = 1'b1} state_t;
  localparam logic [SLOT_W-1:0] BLANK_START = SLOT_W'(SCAN_CYCLES - BLANK_CYCLES - 1);
  state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (slot_q == SLOT_LAST) begin
      state_d = ST_ACTIVE;
    end else if (state_q == ST_ACTIVE && slot_q == BLANK_START) begin
      state_d = ST_BLANK;
    end
  end

  assign active = (state_q == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACTIVE;
    else     state_q <= state_d;
  end
`else
  logic unused_blank;
  assign unused_blank = (BLANK_CYCLES != 0);
  assign active       = 1'b1;
`endif

  // E0 is a prefix only: it neither counts as a make nor disturbs a pending break.
  assign is_make = key_valid && (key_code != 8'hF0) && (key_code != 8'hE0) && !brk_q;

  always_comb begin
    hist_d    = hist_q;
    brk_d     = brk_q;
    led_cnt_d = led_cnt_q;
    slot_d    = slot_q + 1'b1;
    idx_d     = idx_q;
    if (key_valid) begin
      hist_d = {hist_q[7:0], key_code};
      if (key_code == 8'hF0)      brk_d = 1'b1;
      else if (key_code != 8'hE0) brk_d = 1'b0;
    end
    if (is_make)                led_cnt_d = LED_LOAD;
    else if (led_cnt_q != '0)   led_cnt_d = led_cnt_q - 1'b1;
    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // Nibble and anode both derive from the current idx, so they move together.
  always_comb begin
    case (idx_q)
      2'd0:    digit_val_d = hist_q[3:0];
      2'd1:    digit_val_d = hist_q[7:4];
      2'd2:    digit_val_d = hist_q[11:8];
      default: digit_val_d = hist_q[15:12];
    endcase
    an_d = 4'b1111;
    if (active) an_d[idx_q] = 1'b0;
    dp_d  = !(active && idx_q == 2'd2);
    led_d = (led_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q      <= 16'h0000;
      brk_q       <= 1'b0;
      led_cnt_q   <= '0;
      slot_q      <= '0;
      idx_q       <= 2'd0;
      digit_val_q <= 4'h0;
      an_q        <= 4'b1111;
      dp_q        <= 1'b1;
      led_q       <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      brk_q       <= brk_d;
      led_cnt_q   <= led_cnt_d;
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      digit_val_q <= digit_val_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
      led_q       <= led_d;
    end
  end

  assign hist      = hist_q;
  assign digit_val = digit_val_q;
  assign an        = an_q;
  assign dp        = dp_q;
  assign led       = led_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Scoreboard bench for seg7_scan_ctrl (SCAN=8, BLANK=2, LED=5).
// Revision : 1.1 - added direct checks
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int F_AN = 0, F_DP = 1, F_DV = 2, F_LED = 3, F_HIST = 4;
`ifdef SEG7_BLANK_EN
    localparam int ACT = 6, BLK = 2;
    localparam logic [15:0] AN_S31 = 16'h000F;
`else
    localparam int ACT = 8, BLK = 0;
    localparam logic [15:0] AN_S31 = 16'h0007;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic [3:0]  digit_val;
    logic [3:0]  an;
    logic        dp;
    logic        led;
    logic [15:0] hist;

    seg7_scan_ctrl #(.SCAN_CYCLES(8), .BLANK_CYCLES(2), .LED_CYCLES(5)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .digit_val(digit_val), .an(an), .dp(dp), .led(led), .hist(hist)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          fld;
        logic [15:0] val;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                case (sb[i].fld)
                    F_AN:    act = {12'h0, an};
                    F_DP:    act = {15'h0, dp};
                    F_DV:    act = {12'h0, digit_val};
                    F_LED:   act = {15'h0, led};
                    default: act = hist;
                endcase
                n_cmp++;
                if (act !== sb[i].val) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d: got %h want %h", sb[i].nm, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(input int dly, input int fld, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + dly;
        e.fld = fld;
        e.val = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic key(input logic [7:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic reset_release();
        rst = 1'b1;
        key_valid = 1'b0;
        ticks(2);
        rst = 1'b0;
    endtask

    initial begin
        int          k;
        logic [3:0]  a;

        tick();
        n_cmp++;
        if (an !== 4'b1111) begin
            n_err++;
            $display("FAIL direct_rst_an: got %b", an);
        end
        n_cmp++;
        if (hist !== 16'h0000) begin
            n_err++;
            $display("FAIL direct_rst_hist: got %h", hist);
        end
        n_cmp++;
        if (led !== 1'b0) begin
            n_err++;
            $display("FAIL direct_rst_led: got %b", led);
        end
        expect_at(0, F_AN,   16'h000F, "rst_an");
        expect_at(0, F_DP,   16'h0001, "rst_dp");
        expect_at(0, F_DV,   16'h0000, "rst_dv");
        expect_at(0, F_LED,  16'h0000, "rst_led");
        expect_at(0, F_HIST, 16'h0000, "rst_hist");

        reset_release();
        k = 1;
        for (int d = 0; d < 4; d++) begin
            a = ~(4'b0001 << d);
            for (int j = 0; j < ACT; j++) begin
                expect_at(k, F_AN, {12'h0, a}, "sweep_an");
                expect_at(k, F_DP, (d == 2) ? 16'h0000 : 16'h0001, "sweep_dp");
                k++;
            end
            for (int j = 0; j < BLK; j++) begin
                expect_at(k, F_AN, 16'h000F, "sweep_blank_an");
                expect_at(k, F_DP, 16'h0001, "sweep_blank_dp");
                k++;
            end
        end
        expect_at(k, F_AN, 16'h000E, "sweep_wrap_an");
        expect_at(1, F_DV, 16'h0000, "first_dv");
        ticks(k + 1);

        reset_release();
        expect_at(1,  F_HIST, 16'h001C, "cap_hist1");
        expect_at(2,  F_HIST, 16'h1C32, "cap_hist2");
        expect_at(2,  F_DV,   16'h000C, "cap_latency_dv");
        expect_at(4,  F_DV,   16'h0002, "cap_dv_idx0");
        expect_at(12, F_DV,   16'h0003, "cap_dv_idx1");
        expect_at(20, F_DV,   16'h000C, "cap_dv_idx2");
        expect_at(28, F_DV,   16'h0001, "cap_dv_idx3");
        expect_at(6,  F_LED,  16'h0001, "cap_led_retrig");
        expect_at(7,  F_LED,  16'h0000, "cap_led_off");
        key(8'h1C);
        key(8'h32);
        n_cmp++;
        if (hist !== 16'h1C32) begin
            n_err++;
            $display("FAIL direct_cap_hist: got %h", hist);
        end
        ticks(30);

        reset_release();
        expect_at(0, F_LED, 16'h0000, "mk_led_pre");
        for (int j = 1; j <= 5; j++) expect_at(j, F_LED, 16'h0001, "mk_led_on");
        expect_at(6, F_LED, 16'h0000, "mk_led_off");
        key(8'h1C);
        ticks(7);
        expect_at(1, F_LED,  16'h0000, "brk_f0_led");
        expect_at(2, F_LED,  16'h0000, "brk_code_led");
        expect_at(3, F_LED,  16'h0000, "brk_code_led2");
        expect_at(2, F_HIST, 16'hF01C, "brk_hist");
        key(8'hF0);
        key(8'h1C);
        tick();
        expect_at(1, F_LED,  16'h0000, "e0_led");
        expect_at(2, F_LED,  16'h0001, "e0_make_led");
        expect_at(6, F_LED,  16'h0001, "e0_make_led_end");
        expect_at(7, F_LED,  16'h0000, "e0_make_led_off");
        expect_at(2, F_HIST, 16'hE075, "e0_hist");
        key(8'hE0);
        key(8'h75);
        ticks(7);

        reset_release();
        for (int j = 1; j <= 8; j++) expect_at(j, F_LED, 16'h0001, "retrig_led_on");
        expect_at(9, F_LED, 16'h0000, "retrig_led_off");
        key(8'h1C);
        ticks(2);
        key(8'h1C);
        ticks(6);

        expect_at(1, F_HIST, 16'h1C5A, "pre_rst_hist");
        key(8'h5A);
        tick();
        expect_at(0, F_LED,  16'h0001, "pre_rst_led");
        expect_at(1, F_HIST, 16'h0000, "midrst_hist");
        expect_at(1, F_LED,  16'h0000, "midrst_led");
        expect_at(1, F_AN,   16'h000F, "midrst_an");
        expect_at(1, F_DP,   16'h0001, "midrst_dp");
        rst = 1'b1;
        key_valid = 1'b1;
        key_code = 8'h33;
        tick();
        key_valid = 1'b0;
        n_cmp++;
        if (hist !== 16'h0000) begin
            n_err++;
            $display("FAIL direct_midrst_hist: got %h", hist);
        end
        n_cmp++;
        if (led !== 1'b0) begin
            n_err++;
            $display("FAIL direct_midrst_led: got %b", led);
        end
        n_cmp++;
        if (an !== 4'b1111) begin
            n_err++;
            $display("FAIL direct_midrst_an: got %b", an);
        end

        reset_release();
        key(8'h34);
        key(8'h56);
        ticks(29);
        expect_at(0, F_DV,   16'h0003, "bnd_dv_pre");
        expect_at(1, F_HIST, 16'h56AB, "bnd_hist");
        expect_at(1, F_DV,   16'h0003, "bnd_dv_old");
        expect_at(1, F_AN,   AN_S31,   "bnd_an_last");
        expect_at(2, F_DV,   16'h000B, "bnd_dv_new");
        expect_at(2, F_AN,   16'h000E, "bnd_an_wrap");
        key(8'hAB);
        ticks(3);

        ticks(2);
        foreach (sb[i]) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: never compared, want %h", sb[i].nm, sb[i].val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
